// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared FSM state type and dump index sizing for run_monitor
package run_monitor_pkg;
    typedef enum logic [2:0] {IDLE, RUN, SNAP, DUMP, DONE} state_e;
    function automatic int idx_w(input int nregs);
        return $clog2(nregs + 1);
    endfunction
endpackage

// File: rtl/run_monitor_irq_window.sv
// irq_window: one interrupt channel; window latched at run start, registered pulse only in RUN
module irq_window
    import run_monitor_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] start_i,
    input  logic [CNT_W-1:0] len_i,
    input  state_e           state_d_i,
    input  logic [CNT_W-1:0] cnt_d_i,
    output logic             irq_o
);
    logic [CNT_W-1:0] start_q, start_d, len_q, len_d;
    logic [CNT_W:0]   end_w;
    logic             hit;
    // Evaluate the window against next cycle's count so the registered pulse lines up with it
    always_comb begin
        start_d = load_i ? start_i : start_q;
        len_d   = load_i ? len_i : len_q;
        end_w   = {1'b0, start_d} + {1'b0, len_d};
        hit     = state_d_i == RUN && cnt_d_i >= start_d && {1'b0, cnt_d_i} < end_w;
    end
    // Hold the latched window and the registered interrupt line
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            len_q   <= '0;
            irq_o   <= 1'b0;
        end else begin
            start_q <= start_d;
            len_q   <= len_d;
            irq_o   <= hit;
        end
    end
endmodule

// File: rtl/run_monitor.sv
// run_monitor: counts RUN cycles, drives irq windows, ends on completion or budget timeout,
// then snapshots and streams the register file. RUN_MONITOR_CHECKSUM_EN appends a checksum beat.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int NIRQ       = 2,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       completed,
    input  logic [NREGS*XLEN-1:0]      regs_in,
    input  logic [NIRQ*CNT_W-1:0]      irq_start,
    input  logic [NIRQ*CNT_W-1:0]      irq_len,
    output logic [NIRQ-1:0]            irq,
    output logic [CNT_W-1:0]           cycle_count,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [idx_w(NREGS)-1:0]    dump_idx,
    output logic [XLEN-1:0]            dump_data,
    output logic                       dump_last
);
`ifdef RUN_MONITOR_CHECKSUM_EN
    localparam int NBEATS = NREGS + 1;
`else
    localparam int NBEATS = NREGS;
`endif
    localparam int               IW    = idx_w(NREGS);
    localparam logic [IW-1:0]    LAST  = IW'(NBEATS - 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NREGS*XLEN-1:0] snap_q;
    logic [XLEN-1:0]       word;
    logic                  go, lim, fire, last;

    // Next-state, counter, timeout flag and dump index
    always_comb begin
        go   = start && (state_q == IDLE || state_q == DONE);
        lim  = cnt_q == LIMIT;
        fire = dump_valid && dump_ready;
        last = dump_valid && idx_q == LAST;
        case (state_q)
            RUN:     state_d = (completed || lim) ? SNAP : RUN;
            SNAP:    state_d = DUMP;
            DUMP:    state_d = (fire && last) ? DONE : DUMP;
            default: state_d = go ? RUN : state_q;
        endcase
        cnt_d     = go ? '0 : (state_q == RUN && state_d == RUN) ? cnt_q + 1'b1 : cnt_q;
        timeout_d = go ? 1'b0 : (state_q == RUN && !completed && lim) ? 1'b1 : timeout_q;
        idx_d     = go ? '0 : (fire && !last) ? idx_q + 1'b1 : idx_q;
    end

`ifdef RUN_MONITOR_CHECKSUM_EN
    logic [XLEN-1:0] csum;
    // Rotate-left-then-XOR over the snapshot; served on the beat after the last register
    always_comb begin
        csum = '0;
        for (int i = 0; i < NREGS; i++)
            csum = {csum[XLEN-2:0], csum[XLEN-1]} ^ snap_q[i*XLEN +: XLEN];
        word = (int'(idx_q) < NREGS) ? snap_q[int'(idx_q)*XLEN +: XLEN] : csum;
    end
`else
    // Beat data straight from the snapshot
    always_comb word = snap_q[int'(idx_q)*XLEN +: XLEN];
`endif

    // FSM state, run bookkeeping, snapshot capture and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            idx_q      <= '0;
            snap_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            idx_q      <= idx_d;
            snap_q     <= (state_q == SNAP) ? regs_in : snap_q;
            busy       <= state_d inside {RUN, SNAP, DUMP};
            done       <= state_d == DONE;
            dump_valid <= state_d == DUMP;
        end
    end

    // Beat fields are zero outside DUMP and frozen while the consumer stalls
    always_comb begin
        dump_idx  = dump_valid ? idx_q : '0;
        dump_data = dump_valid ? word : '0;
        dump_last = last;
    end

    assign cycle_count = cnt_q;
    assign timeout     = timeout_q;

    for (genvar g = 0; g < NIRQ; g++) begin : g_irq
        irq_window #(.CNT_W(CNT_W)) u_win (
            .clk       (clk),
            .rst       (rst),
            .load_i    (go),
            .start_i   (irq_start[g*CNT_W +: CNT_W]),
            .len_i     (irq_len[g*CNT_W +: CNT_W]),
            .state_d_i (state_d),
            .cnt_d_i   (cnt_d),
            .irq_o     (irq[g])
        );
    end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed self-checking bench for run_monitor (checksum beat when RUN_MONITOR_CHECKSUM_EN)
module tb_run_monitor;
    localparam int XLEN = 32, NREGS = 32, NIRQ = 2, CNT_W = 32, MAXC = 1000;
    localparam int IW = $clog2(NREGS + 1);
`ifdef RUN_MONITOR_CHECKSUM_EN
    localparam int NB = NREGS + 1;
`else
    localparam int NB = NREGS;
`endif
    logic clk = 1'b0;
    logic rst, start, completed, dump_ready;
    logic [NREGS*XLEN-1:0] regs_in;
    logic [NIRQ*CNT_W-1:0] irq_start, irq_len;
    logic [NIRQ-1:0] irq;
    logic [CNT_W-1:0] cycle_count;
    logic busy, done, timeout, dump_valid, dump_last;
    logic [IW-1:0] dump_idx;
    logic [XLEN-1:0] dump_data;
    logic [XLEN-1:0] exp_snap [NREGS];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    run_monitor #(.XLEN(XLEN), .NREGS(NREGS), .NIRQ(NIRQ), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .start(start), .completed(completed), .regs_in(regs_in),
        .irq_start(irq_start), .irq_len(irq_len), .irq(irq), .cycle_count(cycle_count),
        .busy(busy), .done(done), .timeout(timeout), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input int mul, input int add);
        for (int i = 0; i < NREGS; i++) begin
            exp_snap[i] = XLEN'(mul * i + add);
            regs_in[i*XLEN +: XLEN] = exp_snap[i];
        end
    endtask

    function automatic logic [XLEN-1:0] exp_word(input int k);
        logic [XLEN-1:0] c;
        c = '0;
        if (k < NREGS) return exp_snap[k];
        for (int i = 0; i < NREGS; i++) c = ((c << 1) | (c >> (XLEN - 1))) ^ exp_snap[i];
        return c;
    endfunction

    // Start a run, raise completed at cycle_count n, return in the first DUMP cycle
    task automatic run_for(input int n);
        start = 1'b1; tick(); start = 1'b0;
        repeat (n) tick();
        completed = 1'b1; tick(); completed = 1'b0;
        tick();
    endtask

    // Consume nbeats beats in order; optionally hold dump_ready low for stall_n cycles at beat stall_at
    task automatic drain(input string name, input int nbeats, input int stall_at, input int stall_n);
        for (int k = 0; k < nbeats; k++) begin
            total++;
            if ({dump_valid, dump_idx, dump_data, dump_last} !== {1'b1, IW'(k), exp_word(k), k == NB - 1}) begin
                bad++;
                $display("FAIL %s beat %0d: got v=%b idx=%0d data=%h last=%b want v=1 idx=%0d data=%h last=%b",
                         name, k, dump_valid, dump_idx, dump_data, dump_last, k, exp_word(k), k == NB - 1);
            end
            if (k == stall_at) begin
                dump_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    total++;
                    if ({dump_valid, dump_idx, dump_data, dump_last} !== {1'b1, IW'(k), exp_word(k), k == NB - 1}) begin
                        bad++;
                        $display("FAIL %s stall %0d: got v=%b idx=%0d data=%h last=%b want v=1 idx=%0d data=%h",
                                 name, s, dump_valid, dump_idx, dump_data, dump_last, k, exp_word(k));
                    end
                end
            end
            dump_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        total++;
        if ({busy, done, timeout, dump_valid, dump_last, irq, dump_idx, dump_data, cycle_count} !== '0) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b to=%b v=%b last=%b irq=%b idx=%0d data=%h cnt=%0d want all 0",
                     busy, done, timeout, dump_valid, dump_last, irq, dump_idx, dump_data, cycle_count);
        end
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_normal();
        load_regs(7, 1);
        irq_start = {32'd0, 32'd200};
        irq_len   = {32'd0, 32'd1};
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c <= 350; c++) begin
            total++;
            if (cycle_count !== CNT_W'(c) || irq !== ((c == 200) ? 2'b01 : 2'b00) || busy !== 1'b1) begin
                bad++;
                $display("FAIL normal_run c=%0d: got cnt=%0d irq=%b busy=%b want cnt=%0d irq=%b busy=1",
                         c, cycle_count, irq, busy, c, (c == 200) ? 2'b01 : 2'b00);
            end
            if (c == 350) completed = 1'b1;
            tick();
        end
        completed = 1'b0;
        total++;
        if ({busy, dump_valid, irq, timeout} !== 5'b10000 || cycle_count !== 32'd350) begin
            bad++;
            $display("FAIL normal_snap: got busy=%b v=%b irq=%b to=%b cnt=%0d want 1 0 00 0 350",
                     busy, dump_valid, irq, timeout, cycle_count);
        end
        tick();
        regs_in = ~regs_in;
        drain("normal", NB, -1, 0);
        repeat (3) tick();
        total++;
        if ({done, busy, dump_valid, timeout} !== 4'b1000 || cycle_count !== 32'd350) begin
            bad++;
            $display("FAIL normal_done: got done=%b busy=%b v=%b to=%b cnt=%0d want 1 0 0 0 350",
                     done, busy, dump_valid, timeout, cycle_count);
        end
    endtask

    task automatic test_timeout();
        load_regs(5, 100);
        irq_len = '0;
        start = 1'b1; tick(); start = 1'b0;
        total++;
        if (cycle_count !== 32'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart: got cnt=%0d busy=%b want 0 1", cycle_count, busy);
        end
        repeat (MAXC - 1) tick();
        total++;
        if (cycle_count !== 32'd999 || {busy, timeout, dump_valid} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_edge: got cnt=%0d busy=%b to=%b v=%b want 999 1 0 0",
                     cycle_count, busy, timeout, dump_valid);
        end
        tick();
        total++;
        if (cycle_count !== 32'd999 || {timeout, dump_valid} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_snap: got cnt=%0d to=%b v=%b want 999 1 0", cycle_count, timeout, dump_valid);
        end
        tick();
        drain("timeout", NB, -1, 0);
        total++;
        if ({done, timeout} !== 2'b11 || cycle_count !== 32'd999) begin
            bad++;
            $display("FAIL timeout_done: got done=%b to=%b cnt=%0d want 1 1 999", done, timeout, cycle_count);
        end
    endtask

    task automatic test_simultaneous();
        load_regs(1, 0);
        start = 1'b1; tick(); start = 1'b0;
        total++;
        if ({timeout, done} !== 2'b00 || cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL restart_clear: got to=%b done=%b cnt=%0d want 0 0 0", timeout, done, cycle_count);
        end
        repeat (MAXC - 1) tick();
        completed = 1'b1; tick(); completed = 1'b0;
        total++;
        if (timeout !== 1'b0 || cycle_count !== 32'd999 || dump_valid !== 1'b0) begin
            bad++;
            $display("FAIL simultaneous: got to=%b cnt=%0d v=%b want 0 999 0", timeout, cycle_count, dump_valid);
        end
        tick();
        drain("simultaneous", NB, -1, 0);
        total++;
        if ({done, timeout} !== 2'b10) begin
            bad++;
            $display("FAIL simultaneous_done: got done=%b to=%b want 1 0", done, timeout);
        end
    endtask

    task automatic test_backpressure();
        load_regs(11, 3);
        run_for(5);
        drain("backpressure", NB, 5, 2);
        total++;
        if ({done, busy, dump_valid} !== 3'b100 || cycle_count !== 32'd5) begin
            bad++;
            $display("FAIL backpressure_done: got done=%b busy=%b v=%b cnt=%0d want 1 0 0 5",
                     done, busy, dump_valid, cycle_count);
        end
    endtask

    task automatic test_channels();
        load_regs(2, 9);
        irq_start = {32'd10, 32'd0};
        irq_len   = {32'd3, 32'd0};
        start = 1'b1; tick(); start = 1'b0;
        irq_start = '0;
        irq_len   = {32'd0, 32'd50};
        for (int c = 0; c <= 20; c++) begin
            total++;
            if (cycle_count !== CNT_W'(c) || irq !== {(c >= 10 && c <= 12), 1'b0}) begin
                bad++;
                $display("FAIL channels c=%0d: got cnt=%0d irq=%b want cnt=%0d irq=%b",
                         c, cycle_count, irq, c, {(c >= 10 && c <= 12), 1'b0});
            end
            start = (c == 15);
            if (c == 20) completed = 1'b1;
            tick();
        end
        start = 1'b0;
        completed = 1'b0;
        tick();
        drain("channels", NB, -1, 0);
        total++;
        if (done !== 1'b1 || cycle_count !== 32'd20) begin
            bad++;
            $display("FAIL channels_done: got done=%b cnt=%0d want 1 20", done, cycle_count);
        end
    endtask

    task automatic test_reset_mid();
        irq_start = '0;
        irq_len   = {32'd0, 32'd100};
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        total++;
        if (irq !== 2'b01) begin
            bad++;
            $display("FAIL mid_run_irq: got irq=%b want 01", irq);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if ({irq, busy, cycle_count} !== '0) begin
            bad++;
            $display("FAIL mid_run_rst: got irq=%b busy=%b cnt=%0d want 0 0 0", irq, busy, cycle_count);
        end
        irq_len = '0;
        load_regs(13, 9);
        run_for(4);
        drain("pre_reset", 7, -1, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if ({busy, done, timeout, dump_valid, dump_last, irq, dump_idx, dump_data, cycle_count} !== '0) begin
            bad++;
            $display("FAIL mid_dump_rst: got busy=%b done=%b to=%b v=%b last=%b irq=%b idx=%0d data=%h cnt=%0d want all 0",
                     busy, done, timeout, dump_valid, dump_last, irq, dump_idx, dump_data, cycle_count);
        end
        load_regs(3, 0);
        run_for(2);
        drain("fresh", NB, -1, 0);
        total++;
        if ({done, busy, dump_valid} !== 3'b100) begin
            bad++;
            $display("FAIL fresh_done: got done=%b busy=%b v=%b want 1 0 0", done, busy, dump_valid);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; completed = 1'b0; dump_ready = 1'b1;
        regs_in = '0; irq_start = '0; irq_len = '0;
        test_reset();
        test_normal();
        test_timeout();
        test_simultaneous();
        test_backpressure();
        test_channels();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
